// File: rtl/cart_sdram_arbiter.sv
// cart_sdram_arbiter: shares one SDRAM byte port between the HPS download
// stream (buffered through a small write FIFO) and cartridge bus reads.
// Optional one-entry read cache: define CART_ARB_RDCACHE_EN to build it in.
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | no command outstanding; arbitrate and issue next command
// S_WR_WAIT | write issued, waiting for sd_ready_i
// S_RD_WAIT | read issued, waiting for sd_ready_i to capture cart data
module cart_sdram_arbiter #(
  parameter int FIFO_DEPTH  = 8,
  parameter int WAIT_MARGIN = 2
) (
  input  logic        clk_sys_i,
  input  logic        reset_i,
  input  logic        dl_wr_i,
  input  logic [24:0] dl_addr_i,
  input  logic [7:0]  dl_data_i,
  output logic        dl_wait_o,
  output logic        dl_overflow_o,
  input  logic        cart_rd_i,
  input  logic [19:0] cart_a_i,
  output logic [7:0]  cart_d_o,
  output logic        cart_ack_o,
  output logic [24:0] sd_addr_o,
  output logic [7:0]  sd_din_o,
  output logic        sd_we_o,
  output logic        sd_rd_o,
  input  logic [7:0]  sd_dout_i,
  input  logic        sd_ready_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_WR_WAIT, S_RD_WAIT} state_t;

  logic [32:0]      fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d, free_d;
  logic             fifo_empty, fifo_full;
  logic             push, pop, pop_eff;
  logic [32:0]      head;

  state_t           state_q;
  logic             last_grant_q;
  logic             pend_valid_q;
  logic [19:0]      pend_addr_q;
  logic             dl_wait_q, dl_overflow_q, cart_ack_q, sd_we_q, sd_rd_q;
  logic [7:0]       cart_d_q, sd_din_q;
  logic [24:0]      sd_addr_q;

  logic             rd_req, wr_req, grant_wr, grant_rd, dl_wait_d;
  logic [19:0]      rd_addr;
  logic             cart_hit;
  logic [7:0]       cache_dout;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));

`ifdef CART_ARB_RDCACHE_EN
  logic        cache_valid_q;
  logic [19:0] cache_addr_q;
  logic [7:0]  cache_data_q;

  // A hit coinciding with a read completion takes the normal path, so the
  // two acknowledges never merge into one pulse.
  assign cart_hit   = cart_rd_i && cache_valid_q && (cache_addr_q == cart_a_i) &&
                      !(state_q == S_RD_WAIT && sd_ready_i);
  assign cache_dout = cache_data_q;

  // Cache fill on every read completion; any issued write invalidates it.
  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      cache_valid_q <= 1'b0;
      cache_addr_q  <= '0;
      cache_data_q  <= '0;
    end else if (grant_wr) begin
      cache_valid_q <= 1'b0;
    end else if (state_q == S_RD_WAIT && sd_ready_i) begin
      cache_valid_q <= 1'b1;
      cache_addr_q  <= sd_addr_q[19:0];
      cache_data_q  <= sd_dout_i;
    end
  end
`else
  assign cart_hit   = 1'b0;
  assign cache_dout = 8'h00;
`endif

  // Arbitration and FIFO bookkeeping. Incoming requests bypass their
  // registers so an idle arbiter issues on the cycle after the request.
  always_comb begin
    rd_req   = !cart_hit && (cart_rd_i || pend_valid_q);
    rd_addr  = cart_rd_i ? cart_a_i : pend_addr_q;
    wr_req   = !fifo_empty || dl_wr_i;
    head     = fifo_empty ? {dl_addr_i, dl_data_i} : fifo_mem_q[rd_ptr_q];
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state_q == S_IDLE) begin
      if (wr_req && rd_req) begin
        grant_rd = (last_grant_q == GRANT_WR);
        grant_wr = !grant_rd;
      end else begin
        grant_wr = wr_req;
        grant_rd = rd_req;
      end
    end
    pop     = grant_wr;
    pop_eff = pop && !fifo_empty;
    // A write into an empty FIFO that is issued the same cycle never lands.
    push    = dl_wr_i && !fifo_full && !(pop && fifo_empty);
    count_d = count_q;
    if (push && !pop_eff)
      count_d = count_q + CNT_W'(1);
    else if (!push && pop_eff)
      count_d = count_q - CNT_W'(1);
    free_d    = CNT_W'(FIFO_DEPTH) - count_d;
    dl_wait_d = (free_d <= CNT_W'(WAIT_MARGIN));
  end

  // FIFO storage, no reset needed.
  always_ff @(posedge clk_sys_i) begin
    if (push)
      fifo_mem_q[wr_ptr_q] <= {dl_addr_i, dl_data_i};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_eff)
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Command FSM with registered SDRAM and cartridge outputs.
  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      last_grant_q  <= GRANT_RD;
      pend_valid_q  <= 1'b0;
      pend_addr_q   <= '0;
      dl_wait_q     <= 1'b0;
      dl_overflow_q <= 1'b0;
      cart_d_q      <= 8'hFF;
      cart_ack_q    <= 1'b0;
      sd_we_q       <= 1'b0;
      sd_rd_q       <= 1'b0;
      sd_addr_q     <= '0;
      sd_din_q      <= '0;
    end else begin
      sd_we_q    <= 1'b0;
      sd_rd_q    <= 1'b0;
      cart_ack_q <= 1'b0;
      dl_wait_q  <= dl_wait_d;
      if (dl_wr_i && fifo_full)
        dl_overflow_q <= 1'b1;

      if (grant_rd || cart_hit) begin
        pend_valid_q <= 1'b0;
      end else if (cart_rd_i) begin
        pend_valid_q <= 1'b1;
        pend_addr_q  <= cart_a_i;
      end

      if (cart_hit) begin
        cart_d_q   <= cache_dout;
        cart_ack_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (grant_wr) begin
            sd_we_q      <= 1'b1;
            sd_addr_q    <= head[32:8];
            sd_din_q     <= head[7:0];
            last_grant_q <= GRANT_WR;
            state_q      <= S_WR_WAIT;
          end else if (grant_rd) begin
            sd_rd_q      <= 1'b1;
            sd_addr_q    <= {5'b0, rd_addr};
            last_grant_q <= GRANT_RD;
            state_q      <= S_RD_WAIT;
          end
        end
        S_WR_WAIT: begin
          if (sd_ready_i)
            state_q <= S_IDLE;
        end
        S_RD_WAIT: begin
          if (sd_ready_i) begin
            cart_d_q   <= sd_dout_i;
            cart_ack_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dl_wait_o     = dl_wait_q;
  assign dl_overflow_o = dl_overflow_q;
  assign cart_d_o      = cart_d_q;
  assign cart_ack_o    = cart_ack_q;
  assign sd_addr_o     = sd_addr_q;
  assign sd_din_o      = sd_din_q;
  assign sd_we_o       = sd_we_q;
  assign sd_rd_o       = sd_rd_q;

endmodule

// File: tb/tb_cart_sdram_arbiter.sv
// Bench for cart_sdram_arbiter: table-driven reads plus hand-written
// sequences, with a write/read scoreboard checked by a negedge monitor.
module tb_cart_sdram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        dl_wr   = 1'b0;
  logic [24:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        dl_wait, dl_overflow;
  logic        cart_rd = 1'b0;
  logic [19:0] cart_a  = '0;
  logic [7:0]  cart_d;
  logic        cart_ack;
  logic [24:0] sd_addr;
  logic [7:0]  sd_din;
  logic        sd_we, sd_rd;
  logic [7:0]  sd_dout  = '0;
  logic        sd_ready = 1'b0;

  always #5 clk_sys = ~clk_sys;

  cart_sdram_arbiter #(.FIFO_DEPTH(8), .WAIT_MARGIN(2)) dut (
    .clk_sys_i(clk_sys), .reset_i(reset),
    .dl_wr_i(dl_wr), .dl_addr_i(dl_addr), .dl_data_i(dl_data),
    .dl_wait_o(dl_wait), .dl_overflow_o(dl_overflow),
    .cart_rd_i(cart_rd), .cart_a_i(cart_a), .cart_d_o(cart_d), .cart_ack_o(cart_ack),
    .sd_addr_o(sd_addr), .sd_din_o(sd_din), .sd_we_o(sd_we), .sd_rd_o(sd_rd),
    .sd_dout_i(sd_dout), .sd_ready_i(sd_ready)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rd_data(input logic [24:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h78;
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // SDRAM model: answers each command after sd_lat cycles, or follows
  // man_ready/man_dout when sd_manual is set.
  int          sd_lat = 4;
  bit          sd_manual = 1'b0;
  logic        man_ready = 1'b0;
  logic [7:0]  man_dout = '0;
  int          sd_cnt = 0;
  logic [24:0] sd_cmd_addr = '0;
  always begin
    @(posedge clk_sys);
    #2;
    if (sd_manual) begin
      sd_ready = man_ready;
      sd_dout  = man_dout;
      sd_cnt   = 0;
    end else begin
      sd_ready = 1'b0;
      if (sd_cnt > 0) begin
        sd_cnt--;
        if (sd_cnt == 0) begin
          sd_ready = 1'b1;
          sd_dout  = rd_data(sd_cmd_addr);
        end
      end
      if (sd_we || sd_rd) begin
        sd_cnt      = sd_lat;
        sd_cmd_addr = sd_addr;
      end
    end
  end

  // Scoreboard monitor
  typedef struct packed { logic [24:0] addr; logic [7:0] data; } wr_exp_t;
  wr_exp_t    wq[$];
  logic [7:0] rq[$];
  wr_exp_t    we_exp;
  int         n_we = 0;
  int         n_ack = 0;
  always begin
    @(negedge clk_sys);
    if (sd_we || sd_rd)
      check("cmd_exclusive", 32'(sd_we & sd_rd), 32'd0);
    if (sd_we) begin
      n_we++;
      if (wq.size() == 0)
        check("wr_unexpected", 32'(sd_we), 32'd0);
      else begin
        we_exp = wq.pop_front();
        check("wr_addr", 32'(sd_addr), 32'(we_exp.addr));
        check("wr_data", 32'(sd_din), 32'(we_exp.data));
      end
    end
    if (cart_ack) begin
      n_ack++;
      if (rq.size() == 0)
        check("ack_unexpected", 32'(cart_ack), 32'd0);
      else
        check("ack_data", 32'(cart_d), 32'(rq.pop_front()));
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while ((wq.size() != 0 || rq.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    check({name, "_drain"}, 32'(wq.size() + rq.size()), 32'd0);
    repeat (10) tick();
  endtask

  task automatic do_read(input logic [19:0] a, input logic [7:0] exp_d,
                         output logic issued, output logic [24:0] iss_addr,
                         output int ack_cyc);
    cart_rd = 1'b1;
    cart_a  = a;
    rq.push_back(exp_d);
    tick();
    cart_rd  = 1'b0;
    issued   = sd_rd;
    iss_addr = sd_addr;
    ack_cyc  = cart_ack ? 1 : -1;
    for (int c = 2; c <= 30 && ack_cyc < 0; c++) begin
      tick();
      if (cart_ack) ack_cyc = c;
    end
  endtask

  typedef struct {
    logic [19:0] a;
    int          lat;
    logic [24:0] exp_addr;
    logic [7:0]  exp_data;
    int          exp_ack;
  } rd_vec_t;
  rd_vec_t rv[4];

  logic        issued;
  logic [24:0] iss_addr;
  int          ack_cyc, slots, prev_cmd, rdc, seen, wn, we_base, ackb;
  bit          waiting;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rv[0] = '{20'h00123, 4, 25'h0000123, 8'h5A, 6};
    rv[1] = '{20'hFFFFF, 1, 25'h00FFFFF, 8'h78, 3};
    rv[2] = '{20'h00000, 2, 25'h0000000, 8'h78, 4};
    rv[3] = '{20'h8ABCD, 7, 25'h008ABCD, 8'h1E, 9};

    // Reset values
    reset = 1'b1;
    repeat (3) tick();
    check("rst_dl_wait", 32'(dl_wait), 32'd0);
    check("rst_dl_overflow", 32'(dl_overflow), 32'd0);
    check("rst_cart_d", 32'(cart_d), 32'hFF);
    check("rst_cart_ack", 32'(cart_ack), 32'd0);
    check("rst_sd_we", 32'(sd_we), 32'd0);
    check("rst_sd_rd", 32'(sd_rd), 32'd0);
    check("rst_sd_addr", 32'(sd_addr), 32'd0);
    check("rst_sd_din", 32'(sd_din), 32'd0);
    reset = 1'b0;
    tick();

    // Table-driven single reads
    for (int i = 0; i < 4; i++) begin
      sd_lat = rv[i].lat;
      do_read(rv[i].a, rv[i].exp_data, issued, iss_addr, ack_cyc);
      check("rd_issue", 32'(issued), 32'd1);
      check("rd_addr", 32'(iss_addr), 32'(rv[i].exp_addr));
      check("rd_ack_cycle", 32'(ack_cyc), 32'(rv[i].exp_ack));
      tick();
      check("rd_ack_pulse", 32'(cart_ack), 32'd0);
      tick();
      check("rd_cart_d_hold", 32'(cart_d), 32'(rv[i].exp_data));
    end

    // Download burst honoring dl_wait
    sd_lat  = 6;
    we_base = n_we;
    for (int i = 0; i < 64; i++) begin
      int k;
      k = 0;
      while (dl_wait && k < 200) begin
        tick();
        k++;
      end
      dl_wr   = 1'b1;
      dl_addr = 25'(i);
      dl_data = 8'(i);
      wq.push_back(wr_exp_t'{25'(i), 8'(i)});
      tick();
      dl_wr = 1'b0;
    end
    wait_drain("burst", 3000);
    check("burst_overflow", 32'(dl_overflow), 32'd0);
    check("burst_we_count", 32'(n_we - we_base), 32'd64);

    // Overflow with SDRAM stalled and dl_wait ignored
    we_base   = n_we;
    sd_manual = 1'b1;
    man_ready = 1'b0;
    for (int p = 1; p <= 10; p++) begin
      dl_wr   = 1'b1;
      dl_addr = 25'(100 + p);
      dl_data = 8'(8'h80 + p);
      if (p <= 9) wq.push_back(wr_exp_t'{25'(100 + p), 8'(8'h80 + p)});
      tick();
      check("ovf_dl_wait", 32'(dl_wait), 32'(p >= 7));
      check("ovf_flag", 32'(dl_overflow), 32'(p == 10));
    end
    dl_wr = 1'b0;
    tick();
    check("ovf_in_flight", 32'(n_we - we_base), 32'd1);
    man_ready = 1'b1;
    tick();
    man_ready = 1'b0;
    sd_manual = 1'b0;
    sd_lat    = 2;
    wait_drain("ovf", 500);
    check("ovf_sticky", 32'(dl_overflow), 32'd1);
    check("ovf_wait_clear", 32'(dl_wait), 32'd0);

    // Contention: writes always pending, reads every 20 cycles
    sd_lat   = 3;
    waiting  = 1'b0;
    slots    = 0;
    prev_cmd = 0;
    rdc      = 0;
    wn       = 0;
    for (int cyc = 0; cyc < 160; cyc++) begin
      dl_wr = !dl_wait;
      if (dl_wr) begin
        dl_addr = 25'h0001000 + 25'(wn);
        dl_data = 8'(wn * 3);
        wq.push_back(wr_exp_t'{25'h0001000 + 25'(wn), 8'(wn * 3)});
        wn++;
      end
      cart_rd = (cyc % 20 == 5);
      if (cart_rd) begin
        cart_a = 20'h0A000 + 20'(cyc);
        rq.push_back(rd_data({5'b0, 20'h0A000 + 20'(cyc)}));
        waiting = 1'b1;
        slots   = 0;
      end
      tick();
      if ((sd_we || sd_rd) && waiting) slots++;
      if (sd_rd) begin
        rdc++;
        check("cont_rd_slots", 32'(slots <= 2), 32'd1);
        check("cont_prev_we", 32'(prev_cmd), 32'd1);
        waiting = 1'b0;
        prev_cmd = 2;
      end else if (sd_we) begin
        prev_cmd = 1;
      end
    end
    dl_wr   = 1'b0;
    cart_rd = 1'b0;
    wait_drain("cont", 2000);
    check("cont_rd_cmds", 32'(rdc), 32'd8);

    // Reset taken while a read is in flight; stray sd_ready afterwards
    sd_manual = 1'b1;
    man_ready = 1'b0;
    cart_rd   = 1'b1;
    cart_a    = 20'h00777;
    tick();
    cart_rd = 1'b0;
    check("rstrd_issue", 32'(sd_rd), 32'd1);
    tick();
    tick();
    ackb  = n_ack;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    man_dout  = 8'h33;
    man_ready = 1'b1;
    tick();
    man_ready = 1'b0;
    repeat (4) tick();
    check("rstrd_no_ack", 32'(n_ack - ackb), 32'd0);
    check("rstrd_cart_d", 32'(cart_d), 32'hFF);
    check("rstrd_ovf_cleared", 32'(dl_overflow), 32'd0);
    sd_manual = 1'b0;
    sd_lat    = 2;
    do_read(20'h00777, 8'h08, issued, iss_addr, ack_cyc);
    check("rstrd_next_issue", 32'(issued), 32'd1);
    check("rstrd_next_addr", 32'(iss_addr), 32'h777);
    check("rstrd_next_ack", 32'(ack_cyc), 32'd4);
    wait_drain("rstrd", 100);

    // Pending overwrite: two reads while busy, only the latest served
    sd_manual = 1'b1;
    man_ready = 1'b0;
    dl_wr     = 1'b1;
    dl_addr   = 25'h1ABCDEF;
    dl_data   = 8'hC3;
    wq.push_back(wr_exp_t'{25'h1ABCDEF, 8'hC3});
    tick();
    dl_wr   = 1'b0;
    cart_rd = 1'b1;
    cart_a  = 20'h11111;
    tick();
    cart_a = 20'h22345;
    tick();
    cart_rd = 1'b0;
    rq.push_back(rd_data(25'h0022345));
    man_ready = 1'b1;
    tick();
    man_ready = 1'b0;
    sd_manual = 1'b0;
    sd_lat    = 2;
    seen      = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (sd_rd) begin
        seen++;
        check("ovw_addr", 32'(sd_addr), 32'h0022345);
      end
    end
    check("ovw_rd_count", 32'(seen), 32'd1);
    wait_drain("ovw", 100);

    // Repeated read of one address, then a write, then the same read
    sd_lat = 3;
    do_read(20'h00040, 8'h38, issued, iss_addr, ack_cyc);
    check("rep1_issue", 32'(issued), 32'd1);
    check("rep1_ack", 32'(ack_cyc), 32'd5);
    tick();
    do_read(20'h00040, 8'h38, issued, iss_addr, ack_cyc);
`ifdef CART_ARB_RDCACHE_EN
    check("cache_hit_no_sdrd", 32'(issued), 32'd0);
    check("cache_hit_ack", 32'(ack_cyc), 32'd1);
`else
    check("rep2_issue", 32'(issued), 32'd1);
    check("rep2_ack", 32'(ack_cyc), 32'd5);
`endif
    tick();
    dl_wr   = 1'b1;
    dl_addr = 25'h0000500;
    dl_data = 8'h11;
    wq.push_back(wr_exp_t'{25'h0000500, 8'h11});
    tick();
    dl_wr = 1'b0;
    wait_drain("repwr", 100);
    do_read(20'h00040, 8'h38, issued, iss_addr, ack_cyc);
    check("rep3_issue", 32'(issued), 32'd1);
    check("rep3_ack", 32'(ack_cyc), 32'd5);
    wait_drain("final", 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
